// File: rtl/if_id_stage.sv
// Fetch front end: owns the fetch PC, issues instruction-memory requests and holds the IF/ID register,
// with a one-entry skid buffer for fetches that return during a stall. Optional counters under IF_PERF_EN.
module if_id_stage #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [63:0] branch_target,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [63:0] pc_out,
   output logic [31:0] instr_out,
   output logic        valid_out
`ifdef IF_PERF_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
`endif
);

   typedef enum logic {ST_REQ = 1'b0, ST_BUF = 1'b1} state_t;

   state_t      state;
   logic [63:0] fetch_pc;
   logic [63:0] buf_pc;
   logic [31:0] buf_instr;
   logic [63:0] next_pc;

   assign next_pc   = fetch_pc + 64'd4;
   assign imem_req  = (state == ST_REQ);
   assign imem_addr = fetch_pc;

   // BUF state doubles as the "buffer full" flag; REQ always means the buffer is empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_REQ;
         fetch_pc  <= RESET_PC;
         buf_pc    <= 64'h0;
         buf_instr <= NOP_INSTR;
         pc_out    <= 64'h0;
         instr_out <= NOP_INSTR;
         valid_out <= 1'b0;
      end else if (flush) begin
         // Redirect wins over stall and any data returning this cycle.
         state     <= ST_REQ;
         fetch_pc  <= branch_target;
         valid_out <= 1'b0;
         instr_out <= NOP_INSTR;
      end else begin
         case (state)
            ST_REQ: begin
               if (imem_ready) begin
                  fetch_pc <= next_pc;
                  if (!stall) begin
                     pc_out    <= fetch_pc;
                     instr_out <= imem_rdata;
                     valid_out <= 1'b1;
                  end else begin
                     buf_pc    <= fetch_pc;
                     buf_instr <= imem_rdata;
                     state     <= ST_BUF;
                  end
               end else if (!stall) begin
                  valid_out <= 1'b0;
                  instr_out <= NOP_INSTR;
               end
            end
            ST_BUF: begin
               if (!stall) begin
                  pc_out    <= buf_pc;
                  instr_out <= buf_instr;
                  valid_out <= 1'b1;
                  state     <= ST_REQ;
               end
            end
            default: state <= ST_REQ;
         endcase
      end
   end

`ifdef IF_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_count <= 32'h0;
         stall_count <= 32'h0;
      end else begin
         if (imem_req && imem_ready && !flush)
            fetch_count <= fetch_count + 32'd1;
         if (stall)
            stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, streaming fetch, stall/skid, flush, fetch bubbles,
// PC wrap and reset while buffered.
module tb_if_id_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic [63:0] branch_target;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [63:0] pc_out;
   logic [31:0] instr_out;
   logic        valid_out;
`ifdef IF_PERF_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   int n_cmp = 0;
   int n_err = 0;

   if_id_stage dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .flush         (flush),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .pc_out        (pc_out),
      .instr_out     (instr_out),
      .valid_out     (valid_out)
`ifdef IF_PERF_EN
      ,
      .fetch_count   (fetch_count),
      .stall_count   (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = 64'h0;
      imem_ready = 1'b0; imem_rdata = 32'h0;
      tick; tick;
      n_cmp++; if (pc_out !== 64'h0) begin n_err++; $display("FAIL reset_pc_out: got %h want %h", pc_out, 64'h0); end
      n_cmp++; if (instr_out !== 32'h0000_0013) begin n_err++; $display("FAIL reset_instr: got %h want %h", instr_out, 32'h13); end
      n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_out); end
      n_cmp++; if (imem_addr !== 64'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
`ifdef IF_PERF_EN
      n_cmp++; if (fetch_count !== 32'h0 || stall_count !== 32'h0) begin n_err++; $display("FAIL reset_counters: got %h/%h want 0/0", fetch_count, stall_count); end
`endif
      reset = 1'b0;
      #1;
      n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL release_req: got %b want 1", imem_req); end
   endtask

   task automatic test_stream;
      imem_ready = 1'b1; imem_rdata = 32'h0050_0093;
      n_cmp++; if (imem_addr !== 64'h0) begin n_err++; $display("FAIL stream_addr0: got %h want 0", imem_addr); end
      tick;
      n_cmp++; if (pc_out !== 64'h0) begin n_err++; $display("FAIL stream_pc0: got %h want 0", pc_out); end
      n_cmp++; if (instr_out !== 32'h0050_0093) begin n_err++; $display("FAIL stream_instr0: got %h want 00500093", instr_out); end
      n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL stream_valid0: got %b want 1", valid_out); end
      n_cmp++; if (imem_addr !== 64'h4) begin n_err++; $display("FAIL stream_addr1: got %h want 4", imem_addr); end
      imem_rdata = 32'h00A0_0113;
      tick;
      n_cmp++; if (pc_out !== 64'h4) begin n_err++; $display("FAIL stream_pc1: got %h want 4", pc_out); end
      n_cmp++; if (instr_out !== 32'h00A0_0113) begin n_err++; $display("FAIL stream_instr1: got %h want 00a00113", instr_out); end
      n_cmp++; if (imem_addr !== 64'h8) begin n_err++; $display("FAIL stream_addr2: got %h want 8", imem_addr); end
      imem_rdata = 32'h0000_0293;
      tick;
      n_cmp++; if (pc_out !== 64'h8 || instr_out !== 32'h0000_0293) begin n_err++; $display("FAIL stream_pc2: got %h/%h want 8/00000293", pc_out, instr_out); end
   endtask

   task automatic test_stall_skid;
      // Fetch at 0xC returns in the first stall cycle and must be buffered.
      stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h00C0_0313;
      tick;
      imem_ready = 1'b0; imem_rdata = 32'hFFFF_FFFF;
      n_cmp++; if (pc_out !== 64'h8 || instr_out !== 32'h0000_0293) begin n_err++; $display("FAIL stall_hold1: got %h/%h want 8/00000293", pc_out, instr_out); end
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req1: got %b want 0", imem_req); end
      for (int i = 0; i < 2; i++) begin
         tick;
         n_cmp++; if (instr_out !== 32'h0000_0293 || valid_out !== 1'b1) begin n_err++; $display("FAIL stall_hold%0d: got %h/%b want 00000293/1", i + 2, instr_out, valid_out); end
         n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req%0d: got %b want 0", i + 2, imem_req); end
      end
      stall = 1'b0;
      tick;
      n_cmp++; if (pc_out !== 64'hC) begin n_err++; $display("FAIL skid_pc: got %h want c", pc_out); end
      n_cmp++; if (instr_out !== 32'h00C0_0313 || valid_out !== 1'b1) begin n_err++; $display("FAIL skid_instr: got %h/%b want 00c00313/1", instr_out, valid_out); end
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h10) begin n_err++; $display("FAIL skid_next_addr: got %b/%h want 1/10", imem_req, imem_addr); end
   endtask

   task automatic test_flush;
      flush = 1'b1; branch_target = 64'h100; stall = 1'b1;
      imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick;
      flush = 1'b0; stall = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
      n_cmp++; if (valid_out !== 1'b0 || instr_out !== 32'h0000_0013) begin n_err++; $display("FAIL flush_bubble: got %b/%h want 0/00000013", valid_out, instr_out); end
      n_cmp++; if (imem_addr !== 64'h100 || imem_req !== 1'b1) begin n_err++; $display("FAIL flush_addr: got %h/%b want 100/1", imem_addr, imem_req); end
      tick;
      n_cmp++; if (instr_out === 32'hDEAD_BEEF || valid_out !== 1'b0) begin n_err++; $display("FAIL flush_dropped: got %h/%b want 00000013/0", instr_out, valid_out); end
   endtask

   task automatic test_no_ready;
      imem_ready = 1'b0; stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         n_cmp++; if (valid_out !== 1'b0 || instr_out !== 32'h0000_0013) begin n_err++; $display("FAIL noready_bubble%0d: got %b/%h want 0/00000013", i, valid_out, instr_out); end
         n_cmp++; if (imem_addr !== 64'h100) begin n_err++; $display("FAIL noready_addr%0d: got %h want 100", i, imem_addr); end
      end
   endtask

   task automatic test_wrap;
      flush = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
      tick;
      flush = 1'b0;
      n_cmp++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL wrap_start: got %h want fffffffffffffffc", imem_addr); end
      imem_ready = 1'b1; imem_rdata = 32'h0010_0013;
      tick;
      imem_ready = 1'b0;
      n_cmp++; if (imem_addr !== 64'h0) begin n_err++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
      n_cmp++; if (pc_out !== 64'hFFFF_FFFF_FFFF_FFFC || instr_out !== 32'h0010_0013) begin n_err++; $display("FAIL wrap_pc: got %h/%h want fffffffffffffffc/00100013", pc_out, instr_out); end
   endtask

   task automatic test_reset_in_buf;
      flush = 1'b1; branch_target = 64'h200;
      tick;
      flush = 1'b0; stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0020_0093;
      tick;
      imem_ready = 1'b0;
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rbuf_in_buf: got %b want 0", imem_req); end
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (pc_out !== 64'h0 || instr_out !== 32'h0000_0013 || valid_out !== 1'b0) begin n_err++; $display("FAIL rbuf_outputs: got %h/%h/%b want 0/00000013/0", pc_out, instr_out, valid_out); end
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin n_err++; $display("FAIL rbuf_fetch: got %b/%h want 1/0", imem_req, imem_addr); end
`ifdef IF_PERF_EN
      n_cmp++; if (fetch_count !== 32'h0 || stall_count !== 32'h0) begin n_err++; $display("FAIL rbuf_counters: got %h/%h want 0/0", fetch_count, stall_count); end
`endif
      tick;
      reset = 1'b0; stall = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0030_0113;
      #1;
      n_cmp++; if (imem_addr !== 64'h0) begin n_err++; $display("FAIL rbuf_first_addr: got %h want 0", imem_addr); end
      tick;
      imem_ready = 1'b0;
      n_cmp++; if (pc_out !== 64'h0 || instr_out !== 32'h0030_0113 || valid_out !== 1'b1) begin n_err++; $display("FAIL rbuf_first_fetch: got %h/%h/%b want 0/00300113/1", pc_out, instr_out, valid_out); end
   endtask

   initial begin
      test_reset;
      test_stream;
      test_stall_skid;
      test_flush;
      test_no_ready;
      test_wrap;
      test_reset_in_buf;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
